// File: rtl/fp_as_issue_ctrl.sv
// fp_as_issue_ctrl: buffers add/sub requests, issues one per cycle to fp_add_sub, collects results.
// Latency: with empty queues, a request accepted at edge A shows on out_result after edge A+1+LATENCY.
// Backpressure: in_ready drops when the request FIFO is full. Issue stalls while in-flight plus
//   buffered results equal RQ_DEPTH, so a result from the non-stallable adder always has a slot.
// Option: define FP_AS_EXC_FLAGS_EN to compute {nan, inf, zero} at capture and store it with the result.
module fp_as_issue_ctrl #(
  parameter int IQ_DEPTH = 4,
  parameter int RQ_DEPTH = 4,
  parameter int LATENCY  = 1,
  parameter int TAG_W    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_signal,
  input  logic [31:0]      in_a,
  input  logic [31:0]      in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             fpu_signal,
  output logic [31:0]      fpu_a,
  output logic [31:0]      fpu_b,
  input  logic [31:0]      fpu_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_result,
  output logic [TAG_W-1:0] out_tag,
  output logic [2:0]       out_flags,
  output logic             busy
);
  localparam int IQ_AW = $clog2(IQ_DEPTH);
  localparam int RQ_AW = $clog2(RQ_DEPTH);
  localparam logic [IQ_AW:0] IQ_MAX = (IQ_AW+1)'(IQ_DEPTH);
  localparam logic [RQ_AW:0] RQ_MAX = (RQ_AW+1)'(RQ_DEPTH);

  typedef struct packed {
    logic             signal;
    logic [31:0]      a;
    logic [31:0]      b;
    logic [TAG_W-1:0] tag;
  } req_t;

`ifdef FP_AS_EXC_FLAGS_EN
  typedef struct packed {
    logic [31:0]      result;
    logic [TAG_W-1:0] tag;
    logic [2:0]       flags;
  } res_t;
`else
  typedef struct packed {
    logic [31:0]      result;
    logic [TAG_W-1:0] tag;
  } res_t;
`endif

  // ---------------- request FIFO ----------------
  req_t             iq_mem [IQ_DEPTH];
  logic [IQ_AW-1:0] iq_wr_ptr, iq_rd_ptr;
  logic [IQ_AW:0]   iq_count;
  logic             iq_empty, iq_full, iq_push, iq_pop, rst_done;
  req_t             in_req, iq_head;

  assign in_req   = {in_signal, in_a, in_b, in_tag};
  assign iq_head  = iq_mem[iq_rd_ptr];
  assign iq_empty = (iq_count == '0);
  assign iq_full  = (iq_count == IQ_MAX);
  // rst_done keeps in_ready low until the first edge after reset release.
  assign in_ready = rst_done & ~iq_full;
  assign iq_push  = in_valid & in_ready;

  // Request FIFO storage, pointers and occupancy.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      iq_wr_ptr <= '0;
      iq_rd_ptr <= '0;
      iq_count  <= '0;
      rst_done  <= 1'b0;
      for (int i = 0; i < IQ_DEPTH; i++) iq_mem[i] <= '0;
    end else begin
      rst_done <= 1'b1;
      if (iq_push) begin
        iq_mem[iq_wr_ptr] <= in_req;
        iq_wr_ptr         <= iq_wr_ptr + IQ_AW'(1);
      end
      if (iq_pop) iq_rd_ptr <= iq_rd_ptr + IQ_AW'(1);
      iq_count <= iq_count + (IQ_AW+1)'(iq_push) - (IQ_AW+1)'(iq_pop);
    end
  end

  // ---------------- credit-gated issue and latency pipe ----------------
  logic [RQ_AW:0]     inflight_count, rq_count, credits_used;
  logic [LATENCY-1:0] pipe_vld;
  logic [TAG_W-1:0]   pipe_tag [LATENCY];
  logic               capture;

  // Registered counts only: a result popped this cycle frees its credit next cycle.
  assign credits_used = inflight_count + rq_count;
  assign iq_pop       = ~iq_empty & (credits_used < RQ_MAX);
  assign capture      = pipe_vld[LATENCY-1];

  // Issue registers toward fp_add_sub plus the valid/tag shadow of its pipeline.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fpu_a          <= '0;
      fpu_b          <= '0;
      fpu_signal     <= 1'b1;
      pipe_vld       <= '0;
      inflight_count <= '0;
      for (int i = 0; i < LATENCY; i++) pipe_tag[i] <= '0;
    end else begin
      if (iq_pop) begin
        fpu_a      <= iq_head.a;
        fpu_b      <= iq_head.b;
        fpu_signal <= iq_head.signal;
      end
      pipe_vld[0] <= iq_pop;
      pipe_tag[0] <= iq_pop ? iq_head.tag : '0;
      for (int i = 1; i < LATENCY; i++) begin
        pipe_vld[i] <= pipe_vld[i-1];
        pipe_tag[i] <= pipe_tag[i-1];
      end
      inflight_count <= inflight_count + (RQ_AW+1)'(iq_pop) - (RQ_AW+1)'(capture);
    end
  end

  // ---------------- result FIFO ----------------
  res_t             rq_mem [RQ_DEPTH];
  logic [RQ_AW-1:0] rq_wr_ptr, rq_rd_ptr;
  logic             rq_empty, rq_full, rq_pop;
  res_t             cap_res, rq_head;

`ifdef FP_AS_EXC_FLAGS_EN
  logic [7:0]  cap_exp;
  logic [22:0] cap_man;
  logic [2:0]  cap_flags;
  assign cap_exp   = fpu_out[30:23];
  assign cap_man   = fpu_out[22:0];
  assign cap_flags = {(cap_exp == 8'hFF) && (cap_man != '0),
                      (cap_exp == 8'hFF) && (cap_man == '0),
                      (cap_exp == 8'h00) && (cap_man == '0)};
  assign cap_res   = {fpu_out, pipe_tag[LATENCY-1], cap_flags};
  assign out_flags = rq_head.flags;
`else
  assign cap_res   = {fpu_out, pipe_tag[LATENCY-1]};
  assign out_flags = 3'b000;
`endif

  assign rq_head    = rq_mem[rq_rd_ptr];
  assign rq_empty   = (rq_count == '0);
  assign rq_full    = (rq_count == RQ_MAX);
  assign out_valid  = ~rq_empty;
  assign out_result = rq_head.result;
  assign out_tag    = rq_head.tag;
  assign rq_pop     = out_valid & out_ready;
  assign busy       = ~iq_empty | (inflight_count != '0) | ~rq_empty;

  // Result FIFO storage, pointers and occupancy.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rq_wr_ptr <= '0;
      rq_rd_ptr <= '0;
      rq_count  <= '0;
      for (int i = 0; i < RQ_DEPTH; i++) rq_mem[i] <= '0;
    end else begin
      if (capture) begin
        rq_mem[rq_wr_ptr] <= cap_res;
        rq_wr_ptr         <= rq_wr_ptr + RQ_AW'(1);
      end
      if (rq_pop) rq_rd_ptr <= rq_rd_ptr + RQ_AW'(1);
      rq_count <= rq_count + (RQ_AW+1)'(capture) - (RQ_AW+1)'(rq_pop);
    end
  end

  // The credit reservation at issue guarantees a free slot whenever a result arrives.
  assert property (@(posedge clk) disable iff (!rst) capture |-> !rq_full);

endmodule
